vga_frame_ctrl: RTL
===================

# vga_frame_ctrl

Video sequencer for the breakout display pipeline. Generates VGA timing from free-running pixel/line counters: pixel coordinates, sync pulses, the `in_frame` qualifier consumed by the layer mux, and a frame-start strobe. Holds the per-layer enable mask (border, paddle, blocks, ball, lives) in a double-buffered register, so game logic can reconfigure layers at any time and changes only take effect at a frame boundary, with no mid-frame tearing.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `cfg_wr`  in  1  one-cycle write strobe for the layer mask
- `cfg_mask`  in  5  {lives, ball, blocks, paddle, border} enables
- `x`  out  10  current pixel column
- `y`  out  10  current line
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `in_frame`  out  1  high while `x<H_ACTIVE` and `y<V_ACTIVE`
- `frame_start`  out  1  one-cycle pulse while `x==0` and `y==0`
- `layer_en`  out  5  active layer mask, same bit order as `cfg_mask`
- `cfg_pending`  out  1  a written mask is waiting for the next frame

## Operation
- `H_TOTAL` = sum of the H parameters (800). `V_TOTAL` = sum of the V parameters (525).
- `x` increments every cycle and wraps from `H_TOTAL-1` to 0. On that wrap, `y` increments and wraps from `V_TOTAL-1` to 0.
- `hsync` is low while `H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC`.
- `vsync` is low while `V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC`.
- Mask state machine, two states:
  - IDLE: `cfg_pending`=0.
  - PENDING: `cfg_pending`=1.
- `cfg_wr` in any state latches `cfg_mask` into the shadow register and enters PENDING. A later write overwrites the shadow; the last write wins.
- In PENDING, on the cycle the counters wrap to (0,0), copy shadow → `layer_en` and return to IDLE.
- Simultaneous `cfg_wr` and wrap: the wrap transfers the old shadow, the new value enters the shadow, and the state stays PENDING. The new value applies at the following frame.
- Reset (any time, including mid-frame): x=0, y=0, `hsync`=1, `vsync`=1, `in_frame`=1, `frame_start`=1, `layer_en`=5'b11111, shadow=5'b11111, IDLE, `cfg_pending`=0.

## Timing
- `x` and `y` are the counter registers.
- `hsync`, `vsync`, `in_frame` and `frame_start` are registered decodes of the next counter value, so they are cycle-aligned with `x`/`y` and have no combinational path from counters to outputs.
- `layer_en` updates in the same cycle `frame_start` rises.
- `cfg_pending` rises the cycle after `cfg_wr`.
- Write-to-effect latency: from 1 cycle (write on the cycle before the wrap) up to `H_TOTAL*V_TOTAL` cycles.
- Counters are unsigned 10-bit. Parameter sums must stay ≤1023; a larger total is a configuration error.

## Configuration
- `FRAME_COUNT_EN` defined: adds output `frame_cnt` (8 bits, reset 0).
  - Increments on every wrap to (0,0) and wraps 255→0.
  - Gives game logic a timebase for ball speed and blinking lives.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `video_pkg` holds:
  - the default timing constants (640x480@60)
  - layer bit indices `LAYER_BORDER`=0, `LAYER_PADDLE`=1, `LAYER_BLOCKS`=2, `LAYER_BALL`=3, `LAYER_LIVES`=4
  - the mask state encoding.
- One sub-module is natural: `sync_counter`, a generic wrap counter with parameterized total, sync start and sync width. Instantiate it twice, horizontal and vertical, with the vertical instance's enable driven by the horizontal wrap.

## Test plan
- Reset release, run one line → `x` counts 0..799. `hsync` is low exactly for x=656..751 (96 cycles). `in_frame` falls at x=640.
- Run one full frame → `frame_start` pulses once per 420000 cycles. `vsync` is low for y=490..491 only. `in_frame` is 0 for all of y≥480.
- `cfg_wr` with mask 5'b00101 at (100,200) → `cfg_pending`=1 next cycle. `layer_en` stays 11111 until the (0,0) wrap, then becomes 00101 and `cfg_pending`=0.
- Writes 5'b00001 then 5'b10000 in the same frame → only 10000 appears at the wrap.
- `cfg_wr`=5'b01010 on the cycle at (799,524) → that wrap applies the old shadow. `cfg_pending` stays 1, and 01010 appears at the next frame start.
- Assert `rst_n` low at (300,100) with `cfg_pending`=1 → all outputs return to reset values asynchronously, the pending mask is discarded, and counting restarts at (0,0) on release.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared VGA timing defaults, layer bit indices and mask FSM encoding
package video_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int LAYER_BORDER = 0;
    localparam int LAYER_PADDLE = 1;
    localparam int LAYER_BLOCKS = 2;
    localparam int LAYER_BALL   = 3;
    localparam int LAYER_LIVES  = 4;

    localparam logic [4:0] LAYER_ALL = 5'b11111;

    typedef enum logic {
        MASK_IDLE    = 1'b0,
        MASK_PENDING = 1'b1
    } mask_state_t;

endpackage

// File: rtl/sync_counter.sv
// sync_counter: wrap counter with registered decodes (sync, active, zero) of its next value
module sync_counter #(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_WIDTH = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] cnt,
    output logic       wrap,
    output logic       sync_n,
    output logic       active,
    output logic       zero
);

    localparam logic [9:0] LAST = 10'(TOTAL - 1);
    localparam logic [9:0] ACT  = 10'(ACTIVE);
    localparam logic [9:0] SS   = 10'(SYNC_START);
    localparam logic [9:0] SE   = 10'(SYNC_START + SYNC_WIDTH);

    logic [9:0] nxt;

    // next count: advance when enabled, wrap at the last position
    always_comb begin
        wrap = en && (cnt == LAST);
        nxt  = wrap ? 10'd0 : cnt + 10'(en);
    end

    // counter plus decodes of the next value so outputs line up with cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 10'd0;
            sync_n <= 1'b1;
            active <= 1'b1;
            zero   <= 1'b1;
        end else begin
            cnt    <= nxt;
            sync_n <= !((nxt >= SS) && (nxt < SE));
            active <= nxt < ACT;
            zero   <= nxt == 10'd0;
        end
    end

endmodule

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: VGA timing plus frame-synchronous layer mask (optional FRAME_COUNT_EN adds frame_cnt)
module vga_frame_ctrl
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_wr,
    input  logic [4:0] cfg_mask,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       in_frame,
    output logic       frame_start,
    output logic [4:0] layer_en,
    output logic       cfg_pending
`ifdef FRAME_COUNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic        h_wrap, h_act, h_zero;
    logic        v_wrap, v_act, v_zero;
    logic [4:0]  shadow;
    mask_state_t state, state_nxt;

    sync_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_WIDTH(H_SYNC)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .cnt(x), .wrap(h_wrap),
        .sync_n(hsync), .active(h_act), .zero(h_zero)
    );

    sync_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_WIDTH(V_SYNC)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .en(h_wrap), .cnt(y), .wrap(v_wrap),
        .sync_n(vsync), .active(v_act), .zero(v_zero)
    );

    assign in_frame    = h_act & v_act;
    assign frame_start = h_zero & v_zero;

    // a write always (re)arms; otherwise the frame wrap retires the pending mask
    always_comb begin
        state_nxt   = cfg_wr ? MASK_PENDING : (v_wrap ? MASK_IDLE : state);
        cfg_pending = state == MASK_PENDING;
    end

    // mask FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MASK_IDLE;
        else        state <= state_nxt;
    end

    // wrap transfers the old shadow before a coincident write replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= LAYER_ALL;
            layer_en <= LAYER_ALL;
        end else begin
            if (v_wrap && state == MASK_PENDING) layer_en <= shadow;
            if (cfg_wr) shadow <= cfg_mask;
        end
    end

`ifdef FRAME_COUNT_EN
    // free-running frame timebase for game logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      frame_cnt <= 8'd0;
        else if (v_wrap) frame_cnt <= frame_cnt + 8'd1;
    end
`endif

endmodule
